// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, baud constant and command byte codes
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_rx_state_t;
  localparam int BAUD_DIV_19200 = 2604;
  localparam logic [7:0] CMD_GO = 8'h67;
  localparam logic [7:0] CMD_STOP = 8'h73;
endpackage

// File: rtl/uart_cmd_rcv_if.sv
// uart_cmd_rcv_if: command receiver link (RX, clr_rdy in; rx_data, rdy, frm_err out of the receiver)
interface uart_cmd_rcv_if #(parameter int DATA_BITS = 8);
  logic RX;
  logic clr_rdy;
  logic [DATA_BITS-1:0] rx_data;
  logic rdy;
  logic frm_err;
  modport master (output RX, clr_rdy, input rx_data, rdy, frm_err);
  modport slave (input RX, clr_rdy, output rx_data, rdy, frm_err);
endinterface

// File: rtl/uart_baud_tmr.sv
// uart_baud_tmr: loadable baud down-counter (clk, rst, load, load_val in; tick out when count is zero)
module uart_baud_tmr #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tick
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - W'(1);
  assign tick = cnt == '0;
endmodule

// File: rtl/uart_cmd_rcv.sv
// uart_cmd_rcv: 8N1 UART receiver (clk, rst, bus.slave: RX, clr_rdy in; rx_data, sticky rdy, frm_err pulse out)
module uart_cmd_rcv
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_19200,
  parameter int DATA_BITS = 8
) (
  input  logic           clk,
  input  logic           rst,
  uart_cmd_rcv_if.slave  bus
);
  localparam int CW = $clog2(BAUD_DIV);
  localparam int BW = $clog2(DATA_BITS + 1);
  uart_rx_state_t state, state_nx;
  logic rx_m, rx_s, rx_prev;
  logic start_edge, tick, load, shift, take_byte, bad_stop, clr_on_start, first_bit, last_bit;
  logic [CW-1:0] load_val;
  logic [BW-1:0] bit_cnt;
  logic [DATA_BITS-1:0] shreg, rx_data_q;
  logic rdy_q, frm_err_q;
  always_ff @(posedge clk)
    if (rst) {rx_m, rx_s, rx_prev} <= 3'b111;
    else {rx_m, rx_s, rx_prev} <= {bus.RX, rx_m, rx_s};
  assign start_edge = !rx_s && rx_prev;
  uart_baud_tmr #(.W(CW)) u_tmr (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .tick     (tick)
  );
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;
  assign last_bit = bit_cnt == BW'(DATA_BITS - 1);
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  state_nx = start_edge ? START : IDLE;
      START: state_nx = !tick ? START : (rx_s ? IDLE : DATA);
      DATA:  state_nx = (tick && last_bit) ? STOP : DATA;
      STOP:  state_nx = tick ? IDLE : STOP;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    clr_on_start = state == IDLE && start_edge;
    first_bit = state == START && tick && !rx_s;
    shift = state == DATA && tick;
    take_byte = state == STOP && tick && rx_s;
    bad_stop = state == STOP && tick && !rx_s;
    load = clr_on_start || first_bit || shift;
    load_val = state == IDLE ? CW'(BAUD_DIV / 2 - 1) : CW'(BAUD_DIV - 1);
  end
  always_ff @(posedge clk)
    if (rst) begin
      bit_cnt <= '0;
      shreg <= '0;
      rx_data_q <= '0;
      rdy_q <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      if (first_bit) bit_cnt <= '0;
      else if (shift && !last_bit) bit_cnt <= bit_cnt + BW'(1);
      if (shift) shreg <= {rx_s, shreg[DATA_BITS-1:1]};
      if (take_byte) rx_data_q <= shreg;
      if (take_byte) rdy_q <= 1'b1;
      else if (bus.clr_rdy || clr_on_start) rdy_q <= 1'b0;
      frm_err_q <= bad_stop;
    end
  assign bus.rx_data = rx_data_q;
  assign bus.rdy = rdy_q;
  assign bus.frm_err = frm_err_q;
endmodule
